// File: rtl/wb_collector.sv
// wb_collector: buffers the one-cycle result pulses of every execute-stage
// source in a small per-source FIFO and serialises them onto a single
// write-back port using round-robin arbitration.
//
// Handshake: an entry transfers on a cycle where wb_valid_o and wb_ready_i
// are both high. Once wb_valid_o is raised, the grant and all wb_* fields
// are held until that transfer happens. Only a flush can withdraw a
// presented entry. Sources have no back-pressure. They throttle issue
// using src_full_o instead.
module wb_collector #(
   parameter int unsigned NrSrc       = 4,
   parameter int unsigned XLEN        = 64,
   parameter int unsigned TransIdBits = 3,
   parameter int unsigned FifoDepth   = 2
) (
   input  logic                         clk_i,
   input  logic                         rst_ni,
   input  logic                         flush_i,
   input  logic [NrSrc-1:0]             src_valid_i,
   input  logic [NrSrc*TransIdBits-1:0] src_trans_id_i,
   input  logic [NrSrc*XLEN-1:0]        src_result_i,
   input  logic [NrSrc-1:0]             src_ex_valid_i,
   input  logic [NrSrc*XLEN-1:0]        src_ex_cause_i,
   output logic [NrSrc-1:0]             src_full_o,
   output logic                         wb_valid_o,
   input  logic                         wb_ready_i,
   output logic [TransIdBits-1:0]       wb_trans_id_o,
   output logic [XLEN-1:0]              wb_result_o,
   output logic                         wb_ex_valid_o,
   output logic [XLEN-1:0]              wb_ex_cause_o,
   output logic                         overflow_o,
   output logic                         busy_o
);

   localparam int unsigned CntW = $clog2(FifoDepth + 1);
   localparam int unsigned PtrW = (FifoDepth > 1) ? $clog2(FifoDepth) : 1;
   localparam int unsigned IdxW = (NrSrc > 1) ? $clog2(NrSrc) : 1;
   localparam int unsigned SumW = IdxW + 1;

   typedef struct packed {
      logic [TransIdBits-1:0] trans_id;
      logic [XLEN-1:0]        result;
      logic                   ex_valid;
      logic [XLEN-1:0]        ex_cause;
   } entry_t;

   // Pointer advance with wrap at FifoDepth. Non-power-of-two depths also work.
   function automatic logic [PtrW-1:0] ptr_inc(input logic [PtrW-1:0] p);
      if (p == PtrW'(FifoDepth - 1)) begin
         return '0;
      end
      return p + 1'b1;
   endfunction

   entry_t [NrSrc-1:0] head;
   logic   [NrSrc-1:0] not_empty;
   logic   [NrSrc-1:0] full;
   logic   [NrSrc-1:0] push;
   logic   [NrSrc-1:0] pop;
   logic   [NrSrc-1:0] accept;
   logic   [NrSrc-1:0] drop;

   logic [IdxW-1:0] sel;
   logic            found;
   logic            handshake;
   logic [IdxW-1:0] rr_ptr;
   logic            locked;
   logic [IdxW-1:0] lock_idx;
   logic            overflow;
   entry_t          wb_entry;

   assign handshake = wb_valid_o & wb_ready_i;

   for (genvar i = 0; i < NrSrc; i++) begin : g_src
      entry_t          mem [FifoDepth];
      entry_t          in_entry;
      logic [PtrW-1:0] rd_ptr;
      logic [PtrW-1:0] wr_ptr;
      logic [CntW-1:0] cnt;

      assign in_entry.trans_id = src_trans_id_i[i*TransIdBits +: TransIdBits];
      assign in_entry.result   = src_result_i[i*XLEN +: XLEN];
      assign in_entry.ex_valid = src_ex_valid_i[i];
      assign in_entry.ex_cause = src_ex_cause_i[i*XLEN +: XLEN];

      assign not_empty[i]  = (cnt != '0);
      assign full[i]       = (cnt == CntW'(FifoDepth));
      assign src_full_o[i] = (cnt >= CntW'(FifoDepth - 1));
      assign head[i]       = mem[rd_ptr];

      // Flush kills both the incoming pulse and any transfer in the same cycle.
      assign push[i]   = src_valid_i[i] & ~flush_i;
      assign pop[i]    = handshake & (sel == IdxW'(i)) & ~flush_i;
      // A full FIFO still accepts a push if it is popped in the same cycle.
      assign accept[i] = push[i] & (~full[i] | pop[i]);
      assign drop[i]   = push[i] & full[i] & ~pop[i];

      // Occupancy and pointers; a flush empties the FIFO outright.
      always_ff @(posedge clk_i or negedge rst_ni) begin
         if (!rst_ni) begin
            cnt    <= '0;
            rd_ptr <= '0;
            wr_ptr <= '0;
         end else if (flush_i) begin
            cnt    <= '0;
            rd_ptr <= '0;
            wr_ptr <= '0;
         end else begin
            if (accept[i]) begin
               wr_ptr <= ptr_inc(wr_ptr);
            end
            if (pop[i]) begin
               rd_ptr <= ptr_inc(rd_ptr);
            end
            case ({accept[i], pop[i]})
               2'b10:   cnt <= cnt + 1'b1;
               2'b01:   cnt <= cnt - 1'b1;
               default: cnt <= cnt;
            endcase
         end
      end

      // Entry storage. The contents are only meaningful below the count.
      always_ff @(posedge clk_i) begin
         if (accept[i]) begin
            mem[wr_ptr] <= in_entry;
         end
      end
   end

   // Grant selection. A held grant wins. Otherwise, pick the first
   // non-empty FIFO, searching upward from the round-robin pointer.
   always_comb begin
      logic [SumW-1:0] sum;
      logic [IdxW-1:0] cand;
      sel   = rr_ptr;
      found = 1'b0;
      sum   = '0;
      cand  = '0;
      if (locked) begin
         sel   = lock_idx;
         found = 1'b1;
      end else begin
         for (int k = 0; k < int'(NrSrc); k++) begin
            sum = {1'b0, rr_ptr} + SumW'(k);
            if (sum >= SumW'(NrSrc)) begin
               sum = sum - SumW'(NrSrc);
            end
            cand = sum[IdxW-1:0];
            if (!found && not_empty[cand]) begin
               found = 1'b1;
               sel   = cand;
            end
         end
      end
   end

   // Round-robin pointer and stall lock.
   // The lock holds the grant while the write-back port is stalled.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         rr_ptr   <= '0;
         locked   <= 1'b0;
         lock_idx <= '0;
      end else if (flush_i) begin
         rr_ptr   <= '0;
         locked   <= 1'b0;
         lock_idx <= '0;
      end else begin
         locked   <= wb_valid_o & ~wb_ready_i;
         lock_idx <= sel;
         if (handshake) begin
            rr_ptr <= (sel == IdxW'(NrSrc - 1)) ? '0 : sel + 1'b1;
         end
      end
   end

   // Sticky drop indicator. Only reset clears it, and a flush does not.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         overflow <= 1'b0;
      end else if (|drop) begin
         overflow <= 1'b1;
      end
   end

   // An empty selection drives zeros, so stale FIFO contents never leak out.
   assign wb_valid_o    = found & not_empty[sel];
   assign wb_entry      = wb_valid_o ? head[sel] : '0;
   assign wb_trans_id_o = wb_entry.trans_id;
   assign wb_result_o   = wb_entry.result;
   assign wb_ex_valid_o = wb_entry.ex_valid;
   assign wb_ex_cause_o = wb_entry.ex_cause;
   assign overflow_o    = overflow;
   assign busy_o        = |not_empty;

endmodule

// File: tb/tb_wb_collector.sv
// Bench for wb_collector: directed scenarios plus a randomized run checked
// against a queue-based reference model of the collector.
module tb_wb_collector;

   localparam int NrSrc = 4;
   localparam int XLEN  = 64;
   localparam int TID   = 3;
   localparam int DEPTH = 2;

   logic                   clk_i = 1'b0;
   logic                   rst_ni;
   logic                   flush_i;
   logic [NrSrc-1:0]       src_valid_i;
   logic [NrSrc*TID-1:0]   src_trans_id_i;
   logic [NrSrc*XLEN-1:0]  src_result_i;
   logic [NrSrc-1:0]       src_ex_valid_i;
   logic [NrSrc*XLEN-1:0]  src_ex_cause_i;
   logic [NrSrc-1:0]       src_full_o;
   logic                   wb_valid_o;
   logic                   wb_ready_i;
   logic [TID-1:0]         wb_trans_id_o;
   logic [XLEN-1:0]        wb_result_o;
   logic                   wb_ex_valid_o;
   logic [XLEN-1:0]        wb_ex_cause_o;
   logic                   overflow_o;
   logic                   busy_o;

   int checks = 0;
   int errors = 0;

   wb_collector #(
      .NrSrc(NrSrc), .XLEN(XLEN), .TransIdBits(TID), .FifoDepth(DEPTH)
   ) dut (
      .clk_i(clk_i), .rst_ni(rst_ni), .flush_i(flush_i),
      .src_valid_i(src_valid_i), .src_trans_id_i(src_trans_id_i),
      .src_result_i(src_result_i), .src_ex_valid_i(src_ex_valid_i),
      .src_ex_cause_i(src_ex_cause_i), .src_full_o(src_full_o),
      .wb_valid_o(wb_valid_o), .wb_ready_i(wb_ready_i),
      .wb_trans_id_o(wb_trans_id_o), .wb_result_o(wb_result_o),
      .wb_ex_valid_o(wb_ex_valid_o), .wb_ex_cause_o(wb_ex_cause_o),
      .overflow_o(overflow_o), .busy_o(busy_o)
   );

   // ---------------- clock / reset ----------------
   always #5 clk_i = ~clk_i;

   initial begin
      #2_000_000;
      errors++;
      $display("FAIL watchdog: simulation did not finish in time");
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $fatal(1, "watchdog expired");
   end

   // ---------------- reference model ----------------
   typedef struct packed {
      logic [TID-1:0]  id;
      logic [XLEN-1:0] res;
      logic            exv;
      logic [XLEN-1:0] cause;
   } ent_t;

   ent_t mq [NrSrc][$];
   int   m_rr;
   bit   m_lock;
   int   m_lock_idx;
   bit   m_ovf;
   logic [TID-1:0] exp_q[$];

   task automatic model_reset();
      for (int i = 0; i < NrSrc; i++) mq[i].delete();
      m_rr = 0;
      m_lock = 0;
      m_lock_idx = 0;
      m_ovf = 0;
   endtask

   // The entry presented this cycle. While the port is stalled, the previous
   // grant is held. Otherwise the first non-empty source from the
   // round-robin pointer is chosen.
   task automatic model_grant(output bit v, output int g);
      v = 0;
      g = 0;
      if (m_lock) begin
         v = 1;
         g = m_lock_idx;
      end else begin
         for (int k = 0; k < NrSrc; k++) begin
            int j;
            j = (m_rr + k) % NrSrc;
            if (!v && mq[j].size() > 0) begin
               v = 1;
               g = j;
            end
         end
      end
   endtask

   // Advance the model by one clock edge, using the inputs as currently driven.
   task automatic model_step();
      bit   v;
      int   g;
      ent_t e;
      if (flush_i) begin
         for (int i = 0; i < NrSrc; i++) mq[i].delete();
         m_rr = 0;
         m_lock = 0;
         m_lock_idx = 0;
         return;
      end
      model_grant(v, g);
      if (v && wb_ready_i) begin
         e = mq[g].pop_front();
         m_rr = (g + 1) % NrSrc;
      end
      for (int i = 0; i < NrSrc; i++) begin
         if (src_valid_i[i]) begin
            e.id    = src_trans_id_i[i*TID +: TID];
            e.res   = src_result_i[i*XLEN +: XLEN];
            e.exv   = src_ex_valid_i[i];
            e.cause = src_ex_cause_i[i*XLEN +: XLEN];
            if (mq[i].size() < DEPTH) mq[i].push_back(e);
            else m_ovf = 1;
         end
      end
      m_lock = v && !wb_ready_i;
      m_lock_idx = g;
   endtask

   task automatic model_outputs(output logic ev, output ent_t ee,
                                output logic [NrSrc-1:0] ef, output logic eb);
      bit v;
      int g;
      model_grant(v, g);
      ev = v;
      ee = v ? mq[g][0] : '0;
      eb = 0;
      for (int i = 0; i < NrSrc; i++) begin
         ef[i] = (mq[i].size() >= DEPTH - 1);
         if (mq[i].size() > 0) eb = 1;
      end
   endtask

   // ---------------- driver tasks ----------------
   task automatic clear_inputs();
      flush_i        = 1'b0;
      src_valid_i    = '0;
      src_trans_id_i = '0;
      src_result_i   = '0;
      src_ex_valid_i = '0;
      src_ex_cause_i = '0;
   endtask

   task automatic drive_src(input int i, input logic [TID-1:0] id, input logic [XLEN-1:0] res,
                            input logic exv, input logic [XLEN-1:0] cause);
      src_valid_i[i]              = 1'b1;
      src_trans_id_i[i*TID +: TID]  = id;
      src_result_i[i*XLEN +: XLEN]  = res;
      src_ex_valid_i[i]           = exv;
      src_ex_cause_i[i*XLEN +: XLEN] = cause;
   endtask

   // One clock edge. The model sees the same inputs the DUT samples.
   task automatic tick();
      model_step();
      @(posedge clk_i);
      #1;
   endtask

   task automatic apply_reset();
      rst_ni = 1'b0;
      clear_inputs();
      wb_ready_i = 1'b0;
      model_reset();
      @(posedge clk_i); #1;
      @(posedge clk_i); #1;
      rst_ni = 1'b1;
   endtask

   // ---------------- scenarios ----------------
   task automatic test_reset();
      logic ev, eb;
      ent_t ee;
      logic [NrSrc-1:0] ef;
      apply_reset();
      model_outputs(ev, ee, ef, eb);
      checks++;
      if ({wb_valid_o, busy_o, overflow_o, src_full_o} !== {ev, eb, 1'b0, ef} || ev !== 1'b0) begin
         errors++;
         $display("FAIL reset_status: got valid=%b busy=%b ovf=%b full=%b, want 0 0 0 0000",
                  wb_valid_o, busy_o, overflow_o, src_full_o);
      end
      checks++;
      if ({wb_trans_id_o, wb_result_o, wb_ex_valid_o, wb_ex_cause_o} !== '0) begin
         errors++;
         $display("FAIL reset_data: got id=%0d res=%h exv=%b cause=%h, want all zero",
                  wb_trans_id_o, wb_result_o, wb_ex_valid_o, wb_ex_cause_o);
      end
   endtask

   task automatic test_single_push();
      apply_reset();
      wb_ready_i = 1'b1;
      drive_src(0, 3'd3, 64'hAB, 1'b0, 64'h0);
      tick();
      clear_inputs();
      checks++;
      if (wb_valid_o !== 1'b1 || wb_trans_id_o !== 3'd3 || wb_result_o !== 64'hAB) begin
         errors++;
         $display("FAIL single_push: got v=%b id=%0d res=%h, want v=1 id=3 res=ab",
                  wb_valid_o, wb_trans_id_o, wb_result_o);
      end
      tick();
      checks++;
      if (wb_valid_o !== 1'b0) begin
         errors++;
         $display("FAIL single_drain: got v=%b, want 0", wb_valid_o);
      end
   endtask

   task automatic test_fairness();
      logic [XLEN-1:0] res [NrSrc];
      logic [TID-1:0]  exp_id;
      apply_reset();
      wb_ready_i = 1'b1;
      for (int i = 0; i < NrSrc; i++) begin
         res[i] = {$urandom, $urandom};
         drive_src(i, TID'(i), res[i], 1'(i), {$urandom, $urandom});
         exp_q.push_back(TID'(i));
      end
      tick();
      clear_inputs();
      for (int k = 0; k < NrSrc; k++) begin
         exp_id = exp_q.pop_front();
         checks++;
         if (wb_valid_o !== 1'b1 || wb_trans_id_o !== exp_id || wb_result_o !== res[exp_id]) begin
            errors++;
            $display("FAIL fair_order[%0d]: got v=%b id=%0d res=%h, want v=1 id=%0d res=%h",
                     k, wb_valid_o, wb_trans_id_o, wb_result_o, exp_id, res[exp_id]);
         end
         tick();
      end
      drive_src(0, 3'd4, 64'h40, 1'b0, 64'h0);
      drive_src(2, 3'd6, 64'h60, 1'b0, 64'h0);
      exp_q.push_back(3'd4);
      exp_q.push_back(3'd6);
      tick();
      clear_inputs();
      while (exp_q.size() > 0) begin
         exp_id = exp_q.pop_front();
         checks++;
         if (wb_valid_o !== 1'b1 || wb_trans_id_o !== exp_id) begin
            errors++;
            $display("FAIL fair_burst2: got v=%b id=%0d, want v=1 id=%0d",
                     wb_valid_o, wb_trans_id_o, exp_id);
         end
         tick();
      end
   endtask

   task automatic test_stall();
      logic [XLEN-1:0] r1, r0;
      r1 = {$urandom, $urandom};
      r0 = {$urandom, $urandom};
      apply_reset();
      wb_ready_i = 1'b0;
      drive_src(1, 3'd5, r1, 1'b1, 64'h15);
      tick();
      clear_inputs();
      drive_src(0, 3'd6, r0, 1'b0, 64'h0);
      for (int c = 0; c < 5; c++) begin
         checks++;
         if (wb_valid_o !== 1'b1 || wb_trans_id_o !== 3'd5 || wb_result_o !== r1 ||
             wb_ex_valid_o !== 1'b1 || wb_ex_cause_o !== 64'h15) begin
            errors++;
            $display("FAIL stall_hold[%0d]: got v=%b id=%0d res=%h exv=%b, want v=1 id=5 res=%h exv=1",
                     c, wb_valid_o, wb_trans_id_o, wb_result_o, wb_ex_valid_o, r1);
         end
         tick();
         clear_inputs();
      end
      wb_ready_i = 1'b1;
      checks++;
      if (wb_valid_o !== 1'b1 || wb_trans_id_o !== 3'd5) begin
         errors++;
         $display("FAIL stall_release1: got v=%b id=%0d, want v=1 id=5", wb_valid_o, wb_trans_id_o);
      end
      tick();
      checks++;
      if (wb_valid_o !== 1'b1 || wb_trans_id_o !== 3'd6 || wb_result_o !== r0) begin
         errors++;
         $display("FAIL stall_release2: got v=%b id=%0d res=%h, want v=1 id=6 res=%h",
                  wb_valid_o, wb_trans_id_o, wb_result_o, r0);
      end
      tick();
      checks++;
      if (wb_valid_o !== 1'b0 || busy_o !== 1'b0) begin
         errors++;
         $display("FAIL stall_drain: got v=%b busy=%b, want 0 0", wb_valid_o, busy_o);
      end
   endtask

   task automatic test_full();
      apply_reset();
      wb_ready_i = 1'b0;
      drive_src(2, 3'd1, 64'h1, 1'b0, 64'h0);
      tick();
      clear_inputs();
      checks++;
      if (src_full_o !== 4'b0100) begin
         errors++;
         $display("FAIL full_after_one: got full=%b, want 0100", src_full_o);
      end
      drive_src(2, 3'd2, 64'h2, 1'b0, 64'h0);
      tick();
      clear_inputs();
      checks++;
      if (overflow_o !== 1'b0 || src_full_o !== 4'b0100) begin
         errors++;
         $display("FAIL full_at_two: got ovf=%b full=%b, want 0 0100", overflow_o, src_full_o);
      end
      drive_src(2, 3'd3, 64'h3, 1'b0, 64'h0);
      tick();
      clear_inputs();
      checks++;
      if (overflow_o !== 1'b1) begin
         errors++;
         $display("FAIL full_overflow: got ovf=%b, want 1", overflow_o);
      end
      wb_ready_i = 1'b1;
      checks++;
      if (wb_trans_id_o !== 3'd1) begin
         errors++;
         $display("FAIL full_keep1: got id=%0d, want 1", wb_trans_id_o);
      end
      tick();
      checks++;
      if (wb_valid_o !== 1'b1 || wb_trans_id_o !== 3'd2) begin
         errors++;
         $display("FAIL full_keep2: got v=%b id=%0d, want v=1 id=2", wb_valid_o, wb_trans_id_o);
      end
      tick();
      checks++;
      if (wb_valid_o !== 1'b0 || overflow_o !== 1'b1) begin
         errors++;
         $display("FAIL full_sticky: got v=%b ovf=%b, want v=0 ovf=1", wb_valid_o, overflow_o);
      end
   endtask

   task automatic test_push_pop_full();
      apply_reset();
      wb_ready_i = 1'b0;
      drive_src(2, 3'd1, 64'h11, 1'b0, 64'h0);
      tick();
      drive_src(2, 3'd2, 64'h22, 1'b0, 64'h0);
      tick();
      clear_inputs();
      wb_ready_i = 1'b1;
      drive_src(2, 3'd4, 64'h44, 1'b0, 64'h0);
      tick();
      clear_inputs();
      checks++;
      if (overflow_o !== 1'b0 || src_full_o !== 4'b0100 || wb_trans_id_o !== 3'd2) begin
         errors++;
         $display("FAIL pushpop_full: got ovf=%b full=%b id=%0d, want 0 0100 2",
                  overflow_o, src_full_o, wb_trans_id_o);
      end
      tick();
      checks++;
      if (wb_valid_o !== 1'b1 || wb_trans_id_o !== 3'd4 || wb_result_o !== 64'h44) begin
         errors++;
         $display("FAIL pushpop_next: got v=%b id=%0d res=%h, want v=1 id=4 res=44",
                  wb_valid_o, wb_trans_id_o, wb_result_o);
      end
      tick();
      checks++;
      if (wb_valid_o !== 1'b0 || busy_o !== 1'b0) begin
         errors++;
         $display("FAIL pushpop_drain: got v=%b busy=%b, want 0 0", wb_valid_o, busy_o);
      end
   endtask

   task automatic test_flush();
      apply_reset();
      wb_ready_i = 1'b0;
      drive_src(0, 3'd1, 64'h1, 1'b0, 64'h0);
      drive_src(1, 3'd2, 64'h2, 1'b0, 64'h0);
      drive_src(2, 3'd3, 64'h3, 1'b0, 64'h0);
      tick();
      clear_inputs();
      tick();
      checks++;
      if (wb_valid_o !== 1'b1 || busy_o !== 1'b1 || src_full_o !== 4'b0111 || wb_trans_id_o !== 3'd1) begin
         errors++;
         $display("FAIL flush_pre: got v=%b busy=%b full=%b id=%0d, want 1 1 0111 1",
                  wb_valid_o, busy_o, src_full_o, wb_trans_id_o);
      end
      flush_i = 1'b1;
      drive_src(3, 3'd4, 64'h4, 1'b0, 64'h0);
      tick();
      clear_inputs();
      checks++;
      if (wb_valid_o !== 1'b0 || busy_o !== 1'b0 || src_full_o !== 4'b0000) begin
         errors++;
         $display("FAIL flush_post: got v=%b busy=%b full=%b, want 0 0 0000",
                  wb_valid_o, busy_o, src_full_o);
      end
      wb_ready_i = 1'b1;
      drive_src(1, 3'd7, 64'h77, 1'b0, 64'h0);
      tick();
      clear_inputs();
      checks++;
      if (wb_valid_o !== 1'b1 || wb_trans_id_o !== 3'd7) begin
         errors++;
         $display("FAIL flush_repush: got v=%b id=%0d, want v=1 id=7", wb_valid_o, wb_trans_id_o);
      end
      tick();
      checks++;
      if (wb_valid_o !== 1'b0) begin
         errors++;
         $display("FAIL flush_drain: got v=%b, want 0", wb_valid_o);
      end
   endtask

   task automatic test_random();
      logic ev, eb;
      ent_t ee;
      logic [NrSrc-1:0] ef;
      apply_reset();
      for (int c = 0; c < 800; c++) begin
         clear_inputs();
         wb_ready_i = ($urandom_range(0, 3) != 0);
         flush_i = ($urandom_range(0, 39) == 0);
         for (int i = 0; i < NrSrc; i++) begin
            if ($urandom_range(0, 3) == 0)
               drive_src(i, TID'($urandom_range(0, 7)), {$urandom, $urandom},
                         1'($urandom_range(0, 1)), {$urandom, $urandom});
         end
         model_outputs(ev, ee, ef, eb);
         checks++;
         if ({wb_valid_o, wb_trans_id_o, wb_result_o, wb_ex_valid_o, wb_ex_cause_o} !==
             {ev, ee.id, ee.res, ee.exv, ee.cause}) begin
            errors++;
            $display("FAIL rand_wb[%0d]: got v=%b id=%0d res=%h exv=%b cause=%h, want v=%b id=%0d res=%h exv=%b cause=%h",
                     c, wb_valid_o, wb_trans_id_o, wb_result_o, wb_ex_valid_o, wb_ex_cause_o,
                     ev, ee.id, ee.res, ee.exv, ee.cause);
         end
         checks++;
         if ({src_full_o, busy_o, overflow_o} !== {ef, eb, logic'(m_ovf)}) begin
            errors++;
            $display("FAIL rand_status[%0d]: got full=%b busy=%b ovf=%b, want full=%b busy=%b ovf=%b",
                     c, src_full_o, busy_o, overflow_o, ef, eb, m_ovf);
         end
         tick();
      end
      clear_inputs();
   endtask

   // ---------------- sequence and final report ----------------
   initial begin
      rst_ni = 1'b0;
      wb_ready_i = 1'b0;
      clear_inputs();
      test_reset();
      test_single_push();
      test_fairness();
      test_stall();
      test_full();
      test_push_pop_full();
      test_flush();
      test_random();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
